// File: rtl/mem_pkg.sv
// Shared definitions for the RAM port arbiter: FSM states, grant IDs,
// MS_2_0 size codes and read/write polarity.
// No ports; imported by mem_rr_arbiter and mem_port_arbiter.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } mem_state_e;

  // Grant identifiers (also stored as last_grant)
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  // MS_2_0 size/sign codes; bit 2 selects sign extension on reads
  localparam logic [2:0] MSZ_BYTE  = 3'b000;
  localparam logic [2:0] MSZ_HALF  = 3'b001;
  localparam logic [2:0] MSZ_WORD  = 3'b010;
  localparam logic [2:0] MSZ_SBYTE = 3'b100;
  localparam logic [2:0] MSZ_SHALF = 3'b101;

  // ReadWrite polarity
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_rr_arbiter.sv
// Purpose: combinational 2-way round-robin grant between fetch (I) and data (D).
// Latency: zero (pure combinational); ports: i_req_i, d_req_i, last_grant_i in,
// gnt_vld_o, gnt_id_o out. No backpressure: the caller decides when to take the grant.
module mem_rr_arbiter
  import mem_pkg::*;
(
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic last_grant_i,
  output logic gnt_vld_o,
  output logic gnt_id_o
);

  always_comb begin
    gnt_vld_o = i_req_i | d_req_i;
    gnt_id_o  = GNT_I;
    if (i_req_i && d_req_i) begin
      // Tie: the port that did not win last time goes next
      gnt_id_o = (last_grant_i == GNT_I) ? GNT_D : GNT_I;
    end else if (d_req_i) begin
      gnt_id_o = GNT_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: arbitrates fetch (I) and data (D) requesters onto one RAM
// MOV/MOC handshake, returns read data and a one-cycle DONE (plus ERR on timeout).
// Latency: MOV one cycle after grant, DONE one cycle after MOC is sampled;
// backpressure: requests are levels held until DONE, a busy FSM simply defers them.
// Ports: CLK/RESET; I_* fetch port; D_* data port; ERR; MOV/ReadWrite/MS_2_0/
// Address/DataIn/MOC/DataOut RAM side. All outputs are registered.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter logic [2:0] MS_WORD     = MSZ_WORD,
  parameter int         TIMEOUT_CYC = 16,
  parameter int         CNT_W       = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  // fetch port
  input  logic        I_REQ,
  input  logic [31:0] I_ADDR,
  output logic [31:0] I_RDATA,
  output logic        I_DONE,
  // data port
  input  logic        D_REQ,
  input  logic        D_RW,
  input  logic [2:0]  D_MS,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WDATA,
  output logic [31:0] D_RDATA,
  output logic        D_DONE,
  output logic        ERR,
  // RAM side
  output logic        MOV,
  output logic        ReadWrite,
  output logic [2:0]  MS_2_0,
  output logic [31:0] Address,
  output logic [31:0] DataIn,
  input  logic        MOC,
  input  logic [31:0] DataOut
);

  // Last counter value before giving up; used both in WAIT and RELEASE
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  mem_state_e        state_q;
  logic              owner_q;
  logic              last_grant_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_inc;
  logic              mov_q;
  logic              rw_q;
  logic [2:0]        ms_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       i_rdata_q;
  logic [31:0]       d_rdata_q;
  logic              i_done_q;
  logic              d_done_q;
  logic              err_q;

  logic              gnt_vld;
  logic              gnt_id;
  logic              rw_d;
  logic [2:0]        ms_d;
  logic [31:0]       addr_d;
  logic [31:0]       wdata_d;

  mem_rr_arbiter u_arb (
    .i_req_i      (I_REQ),
    .d_req_i      (D_REQ),
    .last_grant_i (last_grant_q),
    .gnt_vld_o    (gnt_vld),
    .gnt_id_o     (gnt_id)
  );

  // Fields latched at grant; the fetch port is always a word read
  always_comb begin
    addr_d  = I_ADDR;
    wdata_d = '0;
    rw_d    = RW_READ;
    ms_d    = MS_WORD;
    if (gnt_id == GNT_D) begin
      addr_d  = D_ADDR;
      wdata_d = D_WDATA;
      rw_d    = D_RW;
      ms_d    = D_MS;
    end
  end

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      owner_q      <= GNT_I;
      last_grant_q <= GNT_D;
      cnt_q        <= '0;
      mov_q        <= 1'b0;
      rw_q         <= 1'b0;
      ms_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // DONE/ERR are single-cycle pulses
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_vld) begin
            owner_q      <= gnt_id;
            last_grant_q <= gnt_id;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rw_q         <= rw_d;
            ms_q         <= ms_d;
            mov_q        <= 1'b1;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // MOC takes priority over a timeout landing in the same cycle
          if (MOC) begin
            mov_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_RELEASE;
            if (owner_q == GNT_I) begin
              i_done_q <= 1'b1;
              if (rw_q == RW_READ) i_rdata_q <= DataOut;
            end else begin
              d_done_q <= 1'b1;
              if (rw_q == RW_READ) d_rdata_q <= DataOut;
            end
          end else if (cnt_inc == TO_LAST) begin
            mov_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b1;
            state_q <= ST_RELEASE;
            if (owner_q == GNT_I) i_done_q <= 1'b1;
            else                  d_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        ST_RELEASE: begin
          // Hold off the next grant until the RAM drops MOC, so a stale
          // MOC cannot complete the next operation; bounded by the timeout
          if (!MOC || (cnt_q == TO_LAST)) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign MOV       = mov_q;
  assign ReadWrite = rw_q;
  assign MS_2_0    = ms_q;
  assign Address   = addr_q;
  assign DataIn    = wdata_q;
  assign I_RDATA   = i_rdata_q;
  assign D_RDATA   = d_rdata_q;
  assign I_DONE    = i_done_q;
  assign D_DONE    = d_done_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RAM model with programmable MOC delay, hang and
// sticky-MOC modes, plus a scoreboard of expected completions per request.
// All sampling and driving happens on the falling clock edge.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        I_REQ = 1'b0;
  logic [31:0] I_ADDR = '0;
  logic [31:0] I_RDATA;
  logic        I_DONE;
  logic        D_REQ = 1'b0;
  logic        D_RW = 1'b0;
  logic [2:0]  D_MS = '0;
  logic [31:0] D_ADDR = '0;
  logic [31:0] D_WDATA = '0;
  logic [31:0] D_RDATA;
  logic        D_DONE;
  logic        ERR;
  logic        MOV;
  logic        ReadWrite;
  logic [2:0]  MS_2_0;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic        MOC = 1'b0;
  logic [31:0] DataOut = '0;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.TIMEOUT_CYC(16)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_RDATA(I_RDATA), .I_DONE(I_DONE),
    .D_REQ(D_REQ), .D_RW(D_RW), .D_MS(D_MS), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_RDATA(D_RDATA), .D_DONE(D_DONE), .ERR(ERR),
    .MOV(MOV), .ReadWrite(ReadWrite), .MS_2_0(MS_2_0), .Address(Address),
    .DataIn(DataIn), .MOC(MOC), .DataOut(DataOut)
  );

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_i_rdata = '0;
  logic [31:0] exp_d_rdata = '0;

  // RAM model knobs and state
  int   k_cfg = 2;
  bit   hang = 1'b0;
  int   sticky_cfg = 0;
  int   mov_cnt = 0;
  int   sticky_left = 0;
  bit   stale = 1'b0;

  // Monitor state
  logic        prev_mov = 1'b0, prev_idone = 1'b0, prev_ddone = 1'b0;
  logic [31:0] cap_addr = '0, cap_din = '0;
  logic        cap_rw = 1'b0;
  logic [2:0]  cap_ms = '0;
  int stab_viol = 0, stale_overlap = 0, mov_hi = 0;
  int i_done_cnt = 0, d_done_cnt = 0, dbl_done = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a == 32'h10) ? 32'hE3A0_0001 : ((a ^ 32'h5A5A_0000) + 32'd1);
  endfunction

  // Monitor first (sees this cycle's values), then the RAM model updates MOC
  always @(negedge CLK) begin
    if (MOV) mov_hi++;
    if (MOV && !prev_mov) begin
      cap_addr = Address; cap_din = DataIn; cap_rw = ReadWrite; cap_ms = MS_2_0;
    end else if (MOV && (Address !== cap_addr || DataIn !== cap_din ||
                         ReadWrite !== cap_rw || MS_2_0 !== cap_ms)) begin
      stab_viol++;
    end
    if (MOV && MOC && stale) stale_overlap++;
    if (I_DONE) begin i_done_cnt++; if (prev_idone) dbl_done++; end
    if (D_DONE) begin d_done_cnt++; if (prev_ddone) dbl_done++; end
    prev_mov = MOV; prev_idone = I_DONE; prev_ddone = D_DONE;

    if (RESET) begin
      MOC = 1'b0; mov_cnt = 0; sticky_left = 0; stale = 1'b0;
    end else if (MOV) begin
      mov_cnt++;
      if (!hang && !MOC && mov_cnt == k_cfg + 1) begin
        MOC = 1'b1; DataOut = mem_rd(Address); sticky_left = sticky_cfg;
      end
    end else begin
      mov_cnt = 0;
      if (MOC) begin
        if (sticky_left > 0) begin sticky_left--; stale = 1'b1; end
        else begin MOC = 1'b0; stale = 1'b0; end
      end
    end
  end

  // Waits for either DONE; cyc counts rising edges from the call
  task automatic wait_done(input int budget, output bit seen, output logic port,
                           output logic [31:0] rd, output logic err, output int cyc);
    seen = 1'b0; port = 1'b0; rd = '0; err = 1'b0; cyc = 0;
    while (!seen && cyc < budget) begin
      @(negedge CLK);
      cyc++;
      if (I_DONE || D_DONE) begin
        seen = 1'b1;
        port = D_DONE;
        rd   = D_DONE ? D_RDATA : I_RDATA;
        err  = ERR;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    total++; if (MOV !== 1'b0) begin bad++; $display("FAIL reset_mov got=%b want=0", MOV); end
    total++; if ({I_DONE, D_DONE, ERR} !== 3'b000) begin bad++; $display("FAIL reset_done got=%b want=000", {I_DONE, D_DONE, ERR}); end
    total++; if ({Address, DataIn} !== 64'h0) begin bad++; $display("FAIL reset_addr_din got=%h want=0", {Address, DataIn}); end
    total++; if ({ReadWrite, MS_2_0} !== 4'h0) begin bad++; $display("FAIL reset_rw_ms got=%h want=0", {ReadWrite, MS_2_0}); end
    total++; if ({I_RDATA, D_RDATA} !== 64'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", {I_RDATA, D_RDATA}); end
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_contention();
    exp_t e; bit seen; logic port; logic [31:0] rd; logic err; int cyc;
    int i0, d0;
    k_cfg = 2;
    i0 = i_done_cnt; d0 = d_done_cnt;
    I_ADDR = 32'h100; D_ADDR = 32'h200; D_RW = RW_READ; D_MS = MSZ_WORD;
    for (int n = 0; n < 4; n++) begin
      e.port  = (n % 2 == 1) ? GNT_D : GNT_I;
      e.rdata = (n % 2 == 1) ? mem_rd(32'h200) : mem_rd(32'h100);
      e.err   = 1'b0;
      sb.push_back(e);
    end
    I_REQ = 1'b1; D_REQ = 1'b1;
    for (int n = 0; n < 4; n++) begin
      wait_done(40, seen, port, rd, err, cyc);
      if (n == 3) begin I_REQ = 1'b0; D_REQ = 1'b0; end
      total++;
      if (!seen || sb.size() == 0) begin
        bad++; $display("FAIL contention_done%0d got=timeout want=done", n);
        I_REQ = 1'b0; D_REQ = 1'b0;
        break;
      end
      e = sb.pop_front();
      total++; if (port !== e.port) begin bad++; $display("FAIL contention_port%0d got=%b want=%b", n, port, e.port); end
      total++; if (rd !== e.rdata || err !== e.err) begin bad++; $display("FAIL contention_data%0d got=%h/%b want=%h/%b", n, rd, err, e.rdata, e.err); end
      if (e.port == GNT_I) exp_i_rdata = e.rdata; else exp_d_rdata = e.rdata;
    end
    repeat (4) @(negedge CLK);
    total++; if ((i_done_cnt - i0) != 2 || (d_done_cnt - d0) != 2) begin
      bad++; $display("FAIL contention_count got=%0d/%0d want=2/2", i_done_cnt - i0, d_done_cnt - d0);
    end
  endtask

  task automatic test_single_fetch();
    exp_t e; bit seen; logic port; logic [31:0] rd; logic err; int cyc; int i0;
    k_cfg = 3;
    i0 = i_done_cnt;
    e.port = GNT_I; e.rdata = 32'hE3A0_0001; e.err = 1'b0; sb.push_back(e);
    I_ADDR = 32'h10; I_REQ = 1'b1;
    wait_done(40, seen, port, rd, err, cyc);
    I_REQ = 1'b0;
    total++;
    if (!seen) begin bad++; $display("FAIL fetch_done got=timeout want=done"); void'(sb.pop_front()); return; end
    e = sb.pop_front();
    total++; if (cyc != 5) begin bad++; $display("FAIL fetch_latency got=%0d want=5", cyc); end
    total++; if (port !== e.port || rd !== e.rdata || err !== e.err) begin
      bad++; $display("FAIL fetch_result got=%b/%h/%b want=%b/%h/%b", port, rd, err, e.port, e.rdata, e.err);
    end
    total++; if ({cap_addr, cap_rw, cap_ms} !== {32'h10, 1'b1, 3'b010}) begin
      bad++; $display("FAIL fetch_fields got=%h/%b/%b want=00000010/1/010", cap_addr, cap_rw, cap_ms);
    end
    exp_i_rdata = e.rdata;
    repeat (3) @(negedge CLK);
    total++; if (I_RDATA !== exp_i_rdata || Address !== 32'h10) begin
      bad++; $display("FAIL fetch_hold got=%h/%h want=%h/00000010", I_RDATA, Address, exp_i_rdata);
    end
    total++; if (i_done_cnt - i0 != 1) begin bad++; $display("FAIL fetch_pulses got=%0d want=1", i_done_cnt - i0); end
  endtask

  task automatic test_byte_write();
    exp_t e; bit seen; logic port; logic [31:0] rd; logic err; int cyc;
    k_cfg = 1;
    e.port = GNT_D; e.rdata = exp_d_rdata; e.err = 1'b0; sb.push_back(e);
    D_RW = RW_WRITE; D_MS = MSZ_BYTE; D_ADDR = 32'h25; D_WDATA = 32'hAB; D_REQ = 1'b1;
    wait_done(40, seen, port, rd, err, cyc);
    D_REQ = 1'b0;
    total++;
    if (!seen) begin bad++; $display("FAIL write_done got=timeout want=done"); void'(sb.pop_front()); return; end
    e = sb.pop_front();
    total++; if (cyc != 3) begin bad++; $display("FAIL write_latency got=%0d want=3", cyc); end
    total++; if (port !== e.port || rd !== e.rdata || err !== e.err) begin
      bad++; $display("FAIL write_result got=%b/%h/%b want=%b/%h/%b", port, rd, err, e.port, e.rdata, e.err);
    end
    total++; if ({cap_addr, cap_din, cap_rw, cap_ms} !== {32'h25, 32'hAB, 1'b0, 3'b000}) begin
      bad++; $display("FAIL write_fields got=%h/%h/%b/%b want=00000025/000000ab/0/000", cap_addr, cap_din, cap_rw, cap_ms);
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_timeout();
    exp_t e; bit seen; logic port; logic [31:0] rd; logic err; int cyc;
    hang = 1'b1;
    mov_hi = 0;
    e.port = GNT_D; e.rdata = exp_d_rdata; e.err = 1'b1; sb.push_back(e);
    D_RW = RW_READ; D_MS = MSZ_WORD; D_ADDR = 32'h40; D_REQ = 1'b1;
    wait_done(60, seen, port, rd, err, cyc);
    D_REQ = 1'b0;
    total++;
    if (!seen) begin bad++; $display("FAIL timeout_done got=timeout want=done"); void'(sb.pop_front()); hang = 1'b0; return; end
    e = sb.pop_front();
    total++; if (port !== e.port || rd !== e.rdata || err !== e.err) begin
      bad++; $display("FAIL timeout_result got=%b/%h/%b want=%b/%h/%b", port, rd, err, e.port, e.rdata, e.err);
    end
    total++; if (mov_hi != 16) begin bad++; $display("FAIL timeout_mov_cycles got=%0d want=16", mov_hi); end
    total++; if (cyc != 17) begin bad++; $display("FAIL timeout_latency got=%0d want=17", cyc); end
    hang = 1'b0;
    repeat (3) @(negedge CLK);
    total++; if ({MOV, ERR, D_DONE} !== 3'b000) begin bad++; $display("FAIL timeout_after got=%b want=000", {MOV, ERR, D_DONE}); end
  endtask

  task automatic test_sticky_moc();
    exp_t e; bit seen; logic port; logic [31:0] rd; logic err; int cyc;
    k_cfg = 2; sticky_cfg = 5;
    e.port = GNT_I; e.rdata = mem_rd(32'h10); e.err = 1'b0; sb.push_back(e);
    I_ADDR = 32'h10; I_REQ = 1'b1;
    wait_done(40, seen, port, rd, err, cyc);
    I_REQ = 1'b0; sticky_cfg = 0;
    total++;
    if (!seen) begin bad++; $display("FAIL sticky_first got=timeout want=done"); void'(sb.pop_front()); return; end
    e = sb.pop_front();
    total++; if (port !== e.port || rd !== e.rdata || cyc != 4) begin
      bad++; $display("FAIL sticky_first_result got=%b/%h/%0d want=%b/%h/4", port, rd, cyc, e.port, e.rdata);
    end
    e.port = GNT_D; e.rdata = mem_rd(32'h80); e.err = 1'b0; sb.push_back(e);
    D_RW = RW_READ; D_MS = MSZ_WORD; D_ADDR = 32'h80; D_REQ = 1'b1;
    wait_done(60, seen, port, rd, err, cyc);
    D_REQ = 1'b0;
    total++;
    if (!seen) begin bad++; $display("FAIL sticky_second got=timeout want=done"); void'(sb.pop_front()); return; end
    e = sb.pop_front();
    total++; if (port !== e.port || rd !== e.rdata || err !== e.err) begin
      bad++; $display("FAIL sticky_second_result got=%b/%h/%b want=%b/%h/%b", port, rd, err, e.port, e.rdata, e.err);
    end
    total++; if (cyc != 10) begin bad++; $display("FAIL sticky_second_latency got=%0d want=10", cyc); end
    exp_i_rdata = mem_rd(32'h10); exp_d_rdata = e.rdata;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_reset_mid_wait();
    exp_t e; bit seen; logic port; logic [31:0] rd; logic err; int cyc;
    int i0, d0; int n;
    hang = 1'b1;
    I_ADDR = 32'h30; I_REQ = 1'b1;
    n = 0;
    while (!MOV && n < 10) begin @(negedge CLK); n++; end
    total++; if (MOV !== 1'b1) begin bad++; $display("FAIL rst_mov_start got=%b want=1", MOV); end
    repeat (3) @(negedge CLK);
    i0 = i_done_cnt; d0 = d_done_cnt;
    RESET = 1'b1; I_REQ = 1'b0;
    @(negedge CLK);
    total++; if (MOV !== 1'b0) begin bad++; $display("FAIL rst_mov_drop got=%b want=0", MOV); end
    RESET = 1'b0; hang = 1'b0;
    exp_i_rdata = '0; exp_d_rdata = '0;
    repeat (20) @(negedge CLK);
    total++; if (i_done_cnt != i0 || d_done_cnt != d0) begin
      bad++; $display("FAIL rst_no_done got=%0d/%0d want=%0d/%0d", i_done_cnt, d_done_cnt, i0, d0);
    end
    k_cfg = 2;
    e.port = GNT_I; e.rdata = mem_rd(32'h34); e.err = 1'b0; sb.push_back(e);
    I_ADDR = 32'h34; D_ADDR = 32'h84; D_RW = RW_READ; D_MS = MSZ_WORD;
    I_REQ = 1'b1; D_REQ = 1'b1;
    wait_done(40, seen, port, rd, err, cyc);
    I_REQ = 1'b0; D_REQ = 1'b0;
    total++;
    if (!seen) begin bad++; $display("FAIL rst_next_done got=timeout want=done"); void'(sb.pop_front()); return; end
    e = sb.pop_front();
    total++; if (port !== e.port || rd !== e.rdata) begin
      bad++; $display("FAIL rst_next_grant got=%b/%h want=%b/%h", port, rd, e.port, e.rdata);
    end
    repeat (4) @(negedge CLK);
    total++; if (D_RDATA !== exp_d_rdata) begin bad++; $display("FAIL rst_d_rdata got=%h want=%h", D_RDATA, exp_d_rdata); end
  endtask

  task automatic test_integrity();
    total++; if (stab_viol != 0) begin bad++; $display("FAIL field_stability got=%0d want=0", stab_viol); end
    total++; if (dbl_done != 0) begin bad++; $display("FAIL done_width got=%0d want=0", dbl_done); end
    total++; if (stale_overlap != 0) begin bad++; $display("FAIL stale_moc_overlap got=%0d want=0", stale_overlap); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_fetch();
    test_byte_write();
    test_timeout();
    test_sticky_moc();
    test_reset_mid_wait();
    test_integrity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
